vga_sync_receiver: RTL

- Receive end of the VGA timing interface. Consumes HS, VS and BLANK_n as driven onto the VGA pins, together with the BGR pixel bus.
- Recovers per-pixel x/y coordinates, measures line and frame geometry, and declares lock.
- Sits on the board-test / loopback path beside vga_controller. Lets the team check the 640x480 timing and drive coordinate-based logic from captured sync alone.

---
 rtl/vga_sync_receiver.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel x/y from captured VGA sync, measures line/frame geometry and declares lock
// Optional feature macro: VGA_RX_CHECKSUM_EN builds a per-frame BGR checksum on oFRAME_SUM.
// Ports: iVGA_CLK pixel clock, iRST_n async active-low reset, iHS/iVS/iBLANK_n/iBGR VGA pins,
//        iCLR_ERR clears the sticky error, oX/oY/oPIX_VALID pixel position, oFRAME_START VS-fall pulse,
//        oLOCKED timing lock, oERR/oERR_CODE sticky first error, oFRAME_SUM per-frame checksum.
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [23:0] iBGR,
    input  logic        iCLR_ERR,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oPIX_VALID,
    output logic        oFRAME_START,
    output logic        oLOCKED,
    output logic        oERR,
    output logic [1:0]  oERR_CODE,
    output logic [23:0] oFRAME_SUM
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_nx;
    logic hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
    logic [9:0] hcnt, x_cnt, line_cnt, vact_cnt, y_cnt;
    logic [2:0] good, good_nx;
    logic err, frame_start;
    logic [1:0] code, bad_code;
    logic hs_fall, vs_fall, bl_fall, line_had_px;
    logic h_tot_bad, h_act_bad, frame_bad, bad;
    logic [10:0] lines_meas, vact_meas;

    function automatic logic [9:0] inc(input logic [9:0] v, input logic en);
        return v + 10'(en && v != 10'h3FF);
    endfunction

    assign hs_fall     = hs_d & ~hs_q;
    assign vs_fall     = vs_d & ~vs_q;
    assign bl_fall     = bl_d & ~bl_q;
    assign line_had_px = x_cnt != '0;
    // A saturated hcnt means HS has been missing for 1024 clocks: flag it without waiting for a fall.
    assign h_tot_bad   = (hcnt == 10'h3FF) || (hs_fall && 11'(hcnt) + 11'd1 != 11'(H_TOTAL));
    assign h_act_bad   = hs_fall && line_had_px && x_cnt != 10'(H_ACTIVE);
    // An HS fall coinciding with the VS fall closes the last line of the ending frame.
    assign lines_meas  = 11'(line_cnt) + 11'(hs_fall);
    assign vact_meas   = 11'(vact_cnt) + 11'(hs_fall && line_had_px);
    assign frame_bad   = vs_fall && (lines_meas != 11'(V_TOTAL) || vact_meas != 11'(V_ACTIVE));
    assign bad         = state != SEARCH && (h_tot_bad || h_act_bad || frame_bad);
    assign bad_code    = h_tot_bad ? 2'b01 : h_act_bad ? 2'b10 : 2'b11;

    always_comb begin
        state_nx = state;
        good_nx  = good;
        if (state == SEARCH) begin
            state_nx = vs_fall ? MEASURE : SEARCH;
            good_nx  = '0;
        end else if (bad) begin
            state_nx = SEARCH;
        end else if (vs_fall) begin
            good_nx  = (good == 3'(LOCK_FRAMES)) ? good : good + 3'd1;
            state_nx = (good_nx == 3'(LOCK_FRAMES)) ? LOCKED : state;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            {hs_q, hs_d, vs_q, vs_d, bl_q, bl_d} <= '0;
            {hcnt, x_cnt, line_cnt, vact_cnt, y_cnt} <= '0;
            state       <= SEARCH;
            good        <= '0;
            err         <= 1'b0;
            code        <= '0;
            frame_start <= 1'b0;
        end else begin
            {hs_q, vs_q, bl_q} <= {iHS, iVS, iBLANK_n};
            {hs_d, vs_d, bl_d} <= {hs_q, vs_q, bl_q};
            hcnt        <= hs_fall ? '0 : inc(hcnt, 1'b1);
            x_cnt       <= hs_fall ? '0 : inc(x_cnt, bl_d);
            line_cnt    <= vs_fall ? '0 : inc(line_cnt, hs_fall);
            vact_cnt    <= vs_fall ? '0 : inc(vact_cnt, hs_fall && line_had_px);
            y_cnt       <= vs_fall ? '0 : inc(y_cnt, bl_fall);
            state       <= state_nx;
            good        <= good_nx;
            err         <= bad | (err & ~iCLR_ERR);
            code        <= (bad && (!err || iCLR_ERR)) ? bad_code : (iCLR_ERR ? 2'b00 : code);
            frame_start <= vs_fall;
        end
    end

    assign oX           = x_cnt;
    assign oY           = y_cnt;
    assign oLOCKED      = state == LOCKED;
    assign oPIX_VALID   = bl_d & oLOCKED;
    assign oFRAME_START = frame_start;
    assign oERR         = err;
    assign oERR_CODE    = code;

`ifdef VGA_RX_CHECKSUM_EN
    logic [23:0] bgr_q, bgr_d, acc, sum;
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            {bgr_q, bgr_d, acc, sum} <= '0;
        end else begin
            bgr_q <= iBGR;
            bgr_d <= bgr_q;
            acc   <= vs_fall ? '0 : acc + (bl_d ? bgr_d : 24'd0);
            if (vs_fall && oLOCKED)
                sum <= acc + (bl_d ? bgr_d : 24'd0);
        end
    end
    assign oFRAME_SUM = sum;
`else
    logic unused_bgr;
    assign unused_bgr = ^iBGR;
    assign oFRAME_SUM = '0;
`endif
endmodule
